// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
//  Shared types and constants for the instruction-fetch stage of the 16-bit
//  pipeline: bus widths, the NOP bubble encoding, reset polarity, the fetch
//  FSM encoding and the IF/ID register control code.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_W = 16;    // instruction word-address bus
    localparam int INST_W      = 16;    // instruction word

    localparam logic [INST_W-1:0] NOP_INST_DEF = 16'h0800;

    // Reset is active-low: this is the level that means "in reset".
    localparam logic RST_ENABLE = 1'b0;

    // Fetch FSM: FETCH keeps a request on the memory port, HOLD parks a
    // completed fetch while decode is frozen.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_t;

    // Sequential next pc, wrapping 16'hFFFF -> 16'h0000.
    function automatic logic [INST_ADDR_W-1:0] pc_inc(input logic [INST_ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//  IF/ID pipeline register. Each edge it either loads a fetched pc/inst pair
//  (valid=1), replaces the instruction with a NOP bubble (valid=0, pc kept),
//  or holds its contents.
// Ports
//  clk          in   clock, rising edge
//  rst          in   asynchronous active-low reset
//  ctrl         in   IFID_LOAD / IFID_BUBBLE / IFID_HOLD
//  load_pc      in   pc to capture on IFID_LOAD
//  load_inst    in   instruction to capture on IFID_LOAD
//  if_pc_o      out  registered pc
//  if_inst_o    out  registered instruction
//  if_valid_o   out  1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ifid_ctrl_t             ctrl,
    input  logic [INST_ADDR_W-1:0] load_pc,
    input  logic [INST_W-1:0]      load_inst,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   if_valid_o
);

    logic [INST_ADDR_W-1:0] pc_reg;
    logic [INST_W-1:0]      inst_reg;
    logic                   valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pc_reg    <= '0;
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    pc_reg    <= load_pc;
                    inst_reg  <= load_inst;
                    valid_reg <= 1'b1;
                end
                IFID_BUBBLE: begin
                    // pc is left as-is; only the instruction becomes a NOP.
                    inst_reg  <= NOP_INST;
                    valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign if_pc_o    = pc_reg;
    assign if_inst_o  = inst_reg;
    assign if_valid_o = valid_reg;

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//  Instruction-fetch stage plus IF/ID register. Fetches over a req/ack memory
//  port with wait states, inserts one bubble per wait cycle, parks a completed
//  fetch in a buffer while decode is stalled, and follows branch redirects
//  from decode with one delay slot.
// Ports
//  clk            in   clock, rising edge
//  rst            in   asynchronous active-low reset
//  stall_i        in   freeze IF/ID
//  branch_flag_i  in   instruction in IF/ID is a taken branch
//  branch_addr_i  in   branch target word address
//  imem_req_o     out  fetch request, held until ack
//  imem_addr_o    out  fetch word address
//  imem_ack_i     in   read data valid (ignored when req=0)
//  imem_rdata_i   in   instruction word
//  if_pc_o        out  IF/ID pc
//  if_inst_o      out  IF/ID instruction
//  if_valid_o     out  IF/ID valid (0 = bubble)
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [INST_W-1:0]      NOP_INST = NOP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_addr_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   if_valid_o
);

    fetch_state_t           state_reg, state_next;
    logic [INST_ADDR_W-1:0] pc_reg, pc_next;
    logic [INST_ADDR_W-1:0] buf_pc_reg, buf_pc_next;
    logic [INST_W-1:0]      buf_inst_reg, buf_inst_next;
    logic                   redir_pend_reg, redir_pend_next;
    logic [INST_ADDR_W-1:0] redir_addr_reg, redir_addr_next;

    ifid_ctrl_t             ifid_ctrl;
    logic [INST_ADDR_W-1:0] ifid_pc;
    logic [INST_W-1:0]      ifid_inst;
    logic                   advance;

    // A new instruction enters IF/ID: either a fetch completing unstalled,
    // or the parked fetch leaving HOLD once the stall clears.
    assign advance = ~stall_i &
                     (((state_reg == ST_FETCH) & imem_ack_i) | (state_reg == ST_HOLD));

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        buf_pc_next     = buf_pc_reg;
        buf_inst_next   = buf_inst_reg;
        redir_pend_next = redir_pend_reg;
        redir_addr_next = redir_addr_reg;
        ifid_ctrl       = IFID_HOLD;
        ifid_pc         = pc_reg;
        ifid_inst       = imem_rdata_i;

        case (state_reg)
            ST_FETCH: begin
                if (imem_ack_i) begin
                    if (!stall_i) begin
                        ifid_ctrl = IFID_LOAD;
                    end else begin
                        // Data would be lost once req drops, so park it.
                        buf_pc_next   = pc_reg;
                        buf_inst_next = imem_rdata_i;
                        state_next    = ST_HOLD;
                    end
                end else if (!stall_i) begin
                    ifid_ctrl = IFID_BUBBLE;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    ifid_ctrl  = IFID_LOAD;
                    ifid_pc    = buf_pc_reg;
                    ifid_inst  = buf_inst_reg;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase

        if (advance) begin
            // The instruction entering IF/ID now is the delay slot; the pc
            // after it is where the branch lands.
            if (branch_flag_i)
                pc_next = branch_addr_i;
            else if (redir_pend_reg)
                pc_next = redir_addr_reg;
            else
                pc_next = pc_inc(pc_reg);
            redir_pend_next = 1'b0;
        end else if (branch_flag_i && !stall_i) begin
            // The branch is about to be overwritten by a bubble while its
            // delay slot is still in flight; remember the target.
            redir_pend_next = 1'b1;
            redir_addr_next = branch_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            buf_pc_reg     <= '0;
            buf_inst_reg   <= NOP_INST;
            redir_pend_reg <= 1'b0;
            redir_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            buf_pc_reg     <= buf_pc_next;
            buf_inst_reg   <= buf_inst_next;
            redir_pend_reg <= redir_pend_next;
            redir_addr_reg <= redir_addr_next;
        end
    end

    // Request drops combinationally with reset so an in-flight access is
    // abandoned in the same cycle.
    assign imem_req_o  = (state_reg == ST_FETCH) && (rst != RST_ENABLE);
    assign imem_addr_o = pc_reg;

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .ctrl       (ifid_ctrl),
        .load_pc    (ifid_pc),
        .load_inst  (ifid_inst),
        .if_pc_o    (if_pc_o),
        .if_inst_o  (if_inst_o),
        .if_valid_o (if_valid_o)
    );

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
//  Self-checking bench for if_fetch. A memory model answers fetches with
//  16'hA000|addr and optional wait states on one address; a decode model
//  raises branch_flag_i when a chosen pc is valid in IF/ID. Each scenario task
//  builds a table of per-edge stimulus plus expected IF/ID and fetch-port
//  values, pushes the expectation when it drives, and pops/compares it on the
//  following falling edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [15:0] branch_addr_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_rdata_i;
    logic [15:0] if_pc_o;
    logic [15:0] if_inst_o;
    logic        if_valid_o;

    // memory model controls
    logic        mem_en    = 1'b0;
    logic        stale_ack = 1'b0;
    logic        slow_en   = 1'b0;
    logic [15:0] slow_addr = 16'h0000;
    int          slow_wait = 0;
    int          wait_cnt  = 0;

    // decode model controls
    logic        br_en     = 1'b0;
    logic [15:0] br_pc     = 16'h0000;
    logic [15:0] br_target = 16'h0000;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic        stall;
        logic        stale;
        logic [15:0] pc;
        logic [15:0] inst;
        logic        valid;
        logic        req;
        logic [15:0] addr;
    } step_t;

    step_t tbl[$];
    step_t sb[$];

    if_fetch #(
        .RESET_PC (16'h0000),
        .NOP_INST (16'h0800)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .if_valid_o    (if_valid_o)
    );

    always #5 clk = ~clk;

    assign imem_ack_i = stale_ack |
        (mem_en && imem_req_o && (!slow_en || imem_addr_o != slow_addr || wait_cnt >= slow_wait));
    assign imem_rdata_i  = 16'hA000 | imem_addr_o;
    assign branch_flag_i = br_en && if_valid_o && (if_pc_o == br_pc);
    assign branch_addr_i = br_target;

    always @(posedge clk) begin
        if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end

    function automatic step_t mk(input logic stall, input logic stale, input logic [15:0] pc,
                                 input logic [15:0] inst, input logic valid, input logic req,
                                 input logic [15:0] addr);
        step_t s;
        s.stall = stall; s.stale = stale; s.pc = pc; s.inst = inst;
        s.valid = valid; s.req = req; s.addr = addr;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b0; stall_i = 1'b0; mem_en = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o} !== {16'h0000, 16'h0800, 1'b0, 1'b0})
            $display("FAIL reset_state: got pc=%h inst=%h valid=%b req=%b, expected pc=0000 inst=0800 valid=0 req=0",
                     if_pc_o, if_inst_o, if_valid_o, imem_req_o);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        check_cnt++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 16'h0000})
            $display("FAIL reset_release: got req=%b addr=%h, expected req=1 addr=0000", imem_req_o, imem_addr_o);
        else pass_cnt++;
        // two fetches so IF/ID holds a real instruction, then a frozen wait at addr 2
        mem_en = 1'b1;
        repeat (2) @(negedge clk);
        mem_en = 1'b0; stall_i = 1'b1;
        @(negedge clk);
        check_cnt++;
        if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {16'h0001, 16'hA001, 1'b1, 1'b1, 16'h0002})
            $display("FAIL reset_prefill: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=0001 inst=a001 valid=1 req=1 addr=0002",
                     if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o);
        else pass_cnt++;
        #2 rst = 1'b0; stale_ack = 1'b1;
        #1;
        check_cnt++;
        if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o} !== {16'h0000, 16'h0800, 1'b0, 1'b0})
            $display("FAIL reset_midwait: got pc=%h inst=%h valid=%b req=%b, expected pc=0000 inst=0800 valid=0 req=0",
                     if_pc_o, if_inst_o, if_valid_o, imem_req_o);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o} !== {16'h0000, 16'h0800, 1'b0, 1'b0})
            $display("FAIL reset_stale_ack: got pc=%h inst=%h valid=%b req=%b, expected pc=0000 inst=0800 valid=0 req=0",
                     if_pc_o, if_inst_o, if_valid_o, imem_req_o);
        else pass_cnt++;
        stale_ack = 1'b0; stall_i = 1'b0; mem_en = 1'b1; rst = 1'b1;
        #1;
        check_cnt++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 16'h0000})
            $display("FAIL reset_rerelease: got req=%b addr=%h, expected req=1 addr=0000", imem_req_o, imem_addr_o);
        else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        step_t s, e;
        int n = 0;
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b0, 1'b0, 16'(k), 16'hA000 | 16'(k), 1'b1, 1'b1, 16'(k + 1)));
        while (tbl.size() > 0) begin
            s = tbl.pop_front();
            stall_i = s.stall; stale_ack = s.stale;
            sb.push_back(s);
            @(negedge clk);
            e = sb.pop_front();
            check_cnt++;
            if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {e.pc, e.inst, e.valid, e.req, e.addr})
                $display("FAIL zero_wait step %0d: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=%h inst=%h valid=%b req=%b addr=%h",
                         n, if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o, e.pc, e.inst, e.valid, e.req, e.addr);
            else pass_cnt++;
            n++;
        end
    endtask

    task automatic test_wait_states();
        step_t s, e;
        int n = 0;
        slow_en = 1'b1; slow_addr = 16'h0005; slow_wait = 2;
        tbl.push_back(mk(1'b0, 1'b0, 16'h0004, 16'hA004, 1'b1, 1'b1, 16'h0005));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0800, 1'b0, 1'b1, 16'h0005));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0800, 1'b0, 1'b1, 16'h0005));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0005, 16'hA005, 1'b1, 1'b1, 16'h0006));
        while (tbl.size() > 0) begin
            s = tbl.pop_front();
            stall_i = s.stall; stale_ack = s.stale;
            sb.push_back(s);
            @(negedge clk);
            e = sb.pop_front();
            check_cnt++;
            if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {e.pc, e.inst, e.valid, e.req, e.addr})
                $display("FAIL wait_states step %0d: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=%h inst=%h valid=%b req=%b addr=%h",
                         n, if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o, e.pc, e.inst, e.valid, e.req, e.addr);
            else pass_cnt++;
            n++;
        end
        slow_en = 1'b0;
    endtask

    task automatic test_stall_hold();
        step_t s, e;
        int n = 0;
        tbl.push_back(mk(1'b0, 1'b0, 16'h0006, 16'hA006, 1'b1, 1'b1, 16'h0007));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0007, 16'hA007, 1'b1, 1'b1, 16'h0008));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0007, 16'hA007, 1'b1, 1'b0, 16'h0008));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0007, 16'hA007, 1'b1, 1'b0, 16'h0008));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0008, 16'hA008, 1'b1, 1'b1, 16'h0009));
        while (tbl.size() > 0) begin
            s = tbl.pop_front();
            stall_i = s.stall; stale_ack = s.stale;
            sb.push_back(s);
            @(negedge clk);
            e = sb.pop_front();
            check_cnt++;
            if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {e.pc, e.inst, e.valid, e.req, e.addr})
                $display("FAIL stall_hold step %0d: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=%h inst=%h valid=%b req=%b addr=%h",
                         n, if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o, e.pc, e.inst, e.valid, e.req, e.addr);
            else pass_cnt++;
            n++;
        end
        stale_ack = 1'b0; stall_i = 1'b0;
    endtask

    task automatic test_branch();
        step_t s, e;
        int n = 0;
        br_en = 1'b1; br_pc = 16'h0010; br_target = 16'h0040;
        for (int k = 9; k <= 16; k++)
            tbl.push_back(mk(1'b0, 1'b0, 16'(k), 16'hA000 | 16'(k), 1'b1, 1'b1, 16'(k + 1)));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0011, 16'hA011, 1'b1, 1'b1, 16'h0040));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0040, 16'hA040, 1'b1, 1'b1, 16'h0041));
        while (tbl.size() > 0) begin
            s = tbl.pop_front();
            stall_i = s.stall; stale_ack = s.stale;
            sb.push_back(s);
            @(negedge clk);
            e = sb.pop_front();
            check_cnt++;
            if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {e.pc, e.inst, e.valid, e.req, e.addr})
                $display("FAIL branch step %0d: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=%h inst=%h valid=%b req=%b addr=%h",
                         n, if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o, e.pc, e.inst, e.valid, e.req, e.addr);
            else pass_cnt++;
            n++;
        end
        br_en = 1'b0;
    endtask

    task automatic test_branch_wait();
        step_t s, e;
        int n = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        br_en = 1'b1; br_pc = 16'h0010; br_target = 16'h0040;
        slow_en = 1'b1; slow_addr = 16'h0011; slow_wait = 2;
        for (int k = 0; k <= 16; k++)
            tbl.push_back(mk(1'b0, 1'b0, 16'(k), 16'hA000 | 16'(k), 1'b1, 1'b1, 16'(k + 1)));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0800, 1'b0, 1'b1, 16'h0011));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0010, 16'h0800, 1'b0, 1'b1, 16'h0011));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0011, 16'hA011, 1'b1, 1'b1, 16'h0040));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0040, 16'hA040, 1'b1, 1'b1, 16'h0041));
        while (tbl.size() > 0) begin
            s = tbl.pop_front();
            stall_i = s.stall; stale_ack = s.stale;
            sb.push_back(s);
            @(negedge clk);
            e = sb.pop_front();
            check_cnt++;
            if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {e.pc, e.inst, e.valid, e.req, e.addr})
                $display("FAIL branch_wait step %0d: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=%h inst=%h valid=%b req=%b addr=%h",
                         n, if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o, e.pc, e.inst, e.valid, e.req, e.addr);
            else pass_cnt++;
            n++;
        end
        br_en = 1'b0; slow_en = 1'b0;
    endtask

    task automatic test_wrap();
        step_t s, e;
        int n = 0;
        br_en = 1'b1; br_pc = 16'h0041; br_target = 16'hFFFF;
        tbl.push_back(mk(1'b0, 1'b0, 16'h0041, 16'hA041, 1'b1, 1'b1, 16'h0042));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0042, 16'hA042, 1'b1, 1'b1, 16'hFFFF));
        tbl.push_back(mk(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 16'hA000, 1'b1, 1'b1, 16'h0001));
        while (tbl.size() > 0) begin
            s = tbl.pop_front();
            stall_i = s.stall; stale_ack = s.stale;
            sb.push_back(s);
            @(negedge clk);
            e = sb.pop_front();
            check_cnt++;
            if ({if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o} !== {e.pc, e.inst, e.valid, e.req, e.addr})
                $display("FAIL wrap step %0d: got pc=%h inst=%h valid=%b req=%b addr=%h, expected pc=%h inst=%h valid=%b req=%b addr=%h",
                         n, if_pc_o, if_inst_o, if_valid_o, imem_req_o, imem_addr_o, e.pc, e.inst, e.valid, e.req, e.addr);
            else pass_cnt++;
            n++;
        end
        br_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch();
        test_branch_wait();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
